// File: rtl/prime_req_arbiter.sv
// Round-robin front end that time-shares one is_prime checker between NREQ
// valid/ready requesters and reports the checker latency of each finished job.
module prime_req_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    parameter  int LAT_W = 16,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_number,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  rsp_result,
    output logic                  chk_valid,
    input  logic                  chk_ready,
    output logic [WIDTH-1:0]      chk_number,
    input  logic                  chk_done,
    input  logic                  chk_result,
    output logic                  chk_ack,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [LAT_W-1:0]      last_latency
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [IDW-1:0]    r_rr, r_grant;
    logic [WIDTH-1:0]  r_num;
    logic              r_res;
    logic [LAT_W-1:0]  r_lat, r_last;

    logic [2*NREQ-1:0] w_dbl;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_win;
    logic              w_found;
    logic              w_accept, w_rsp_acc, w_done;
    logic [LAT_W-1:0]  w_lat_inc;
    logic [NREQ-1:0]   w_one;

    assign w_one = {{(NREQ-1){1'b0}}, 1'b1};

    // Rotate the valid vector so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        w_dbl   = {req_valid, req_valid} >> r_rr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_sum   = {1'b0, r_rr} + (IDW+1)'(k);
                w_found = 1'b1;
            end
        end
        if (w_sum >= (IDW+1)'(NREQ))
            w_sum = w_sum - (IDW+1)'(NREQ);
        w_win = w_sum[IDW-1:0];
    end

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_rsp_acc = (r_state == S_RESP) && rsp_ready[r_grant];
    assign w_done    = (r_state == S_WAIT) && chk_done;
    assign w_lat_inc = (&r_lat) ? r_lat : r_lat + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_ISSUE;
            S_ISSUE: if (chk_ready) w_next = S_WAIT;
            S_WAIT:  if (chk_done)  w_next = S_RESP;
            S_RESP:  if (w_rsp_acc) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign req_ready    = w_accept ? (w_one << w_win) : '0;
    assign rsp_valid    = (r_state == S_RESP) ? (w_one << r_grant) : '0;
    assign rsp_result   = (r_state == S_RESP) && r_res;
    assign chk_valid    = (r_state == S_ISSUE);
    assign chk_ack      = (r_state == S_WAIT);
    assign chk_number   = (r_state == S_IDLE) ? '0 : r_num;
    assign busy         = (r_state != S_IDLE);
    assign grant_id     = r_grant;
    assign last_latency = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_grant <= '0;
            r_num   <= '0;
            r_res   <= 1'b0;
            r_lat   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_num   <= req_number[w_win*WIDTH +: WIDTH];
                r_grant <= w_win;
                r_lat   <= '0;
            end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
                r_lat <= w_lat_inc;
            end
            // The completing WAIT cycle is counted in the reported latency.
            if (w_done) begin
                r_res  <= chk_result;
                r_last <= w_lat_inc;
            end
            if (w_rsp_acc)
                r_rr <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
        end
    end

endmodule

// File: tb/tb_prime_req_arbiter.sv
// Directed bench for prime_req_arbiter with a behavioural is_prime checker
// whose response delay is set per scenario.
module tb_prime_req_arbiter;
    localparam int W = 32, N = 4, LW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]   req_number;
    logic             rsp_result, chk_valid, chk_ready, chk_done, chk_result, chk_ack, busy;
    logic [W-1:0]     chk_number;
    logic [1:0]       grant_id;
    logic [LW-1:0]    last_latency;

    int checks = 0, failures = 0;
    int chk_delay = 0;

    prime_req_arbiter #(.WIDTH(W), .NREQ(N), .LAT_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_number(req_number),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_number(chk_number),
        .chk_done(chk_done), .chk_result(chk_result), .chk_ack(chk_ack),
        .grant_id(grant_id), .busy(busy), .last_latency(last_latency)
    );

    always #5 clk = ~clk;

    function automatic logic is_prime_ref(input logic [31:0] n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= int'(n); d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Checker model: always ready; answers chk_delay cycles after entering WAIT.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] num;
        pend = 0; cnt = 0; num = 0;
        chk_ready = 1'b1; chk_done = 1'b0; chk_result = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_done = 1'b0; pend = 0;
            end else if (chk_done) begin
                chk_done = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    chk_done = 1'b1; chk_result = is_prime_ref(num); pend = 0;
                end else cnt--;
            end else if (chk_valid && chk_ready) begin
                pend = 1; num = chk_number; cnt = chk_delay;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_number = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_job(input int idx, input logic [31:0] num,
                           output logic res, output logic [LW-1:0] lat, output logic ok);
        int t;
        ok = 1'b1;
        @(negedge clk);
        req_number[idx*W +: W] = num; req_valid[idx] = 1'b1; #1;
        t = 0;
        while (!req_ready[idx] && t < 200) begin @(negedge clk); #1; t++; end
        if (!req_ready[idx]) ok = 1'b0;
        @(negedge clk);
        req_valid[idx] = 1'b0;
        t = 0;
        while (!rsp_valid[idx] && t < 200) begin @(negedge clk); t++; end
        if (!rsp_valid[idx]) ok = 1'b0;
        res = rsp_result; lat = last_latency;
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        rsp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_number = '0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, chk_valid, chk_ack, busy, rsp_result} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, rsp_valid, chk_valid, chk_ack, busy, rsp_result});
        end
        checks++;
        if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        checks++;
        if (last_latency !== '0) begin failures++; $display("FAIL reset_latency got=%0d exp=0", last_latency); end
        checks++;
        if (chk_number !== '0) begin failures++; $display("FAIL reset_chk_number got=%0d exp=0", chk_number); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [LW-1:0] lat0;

    task automatic test_single();
        int t;
        chk_delay = 0;
        @(negedge clk);
        req_number[0 +: W] = 32'd7; req_valid[0] = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if ({chk_valid, chk_number} !== {1'b1, 32'd7}) begin
            failures++; $display("FAIL single_issue got valid=%b num=%0d exp valid=1 num=7", chk_valid, chk_number);
        end
        checks++;
        if ({busy, grant_id} !== 3'b100) begin failures++; $display("FAIL single_busy_grant got=%b exp=100", {busy, grant_id}); end
        t = 0;
        while (rsp_valid == '0 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 1'b1) begin
            failures++; $display("FAIL single_rsp got valid=%b res=%b exp valid=0001 res=1", rsp_valid, rsp_result);
        end
        checks++;
        if (!(last_latency > 0)) begin failures++; $display("FAIL single_latency got=%0d exp>0", last_latency); end
        lat0 = last_latency;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_operands();
        logic [31:0]   nums [4] = '{32'd9, 32'd2, 32'd1, 32'd4};
        logic          exps [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic          res, ok;
        logic [LW-1:0] lat;
        for (int i = 0; i < 4; i++) begin
            run_job(2, nums[i], res, lat, ok);
            checks++;
            if (!ok || res !== exps[i]) begin
                failures++; $display("FAIL operand_%0d got ok=%b res=%b exp ok=1 res=%b", nums[i], ok, res, exps[i]);
            end
        end
        chk_delay = 5;
        run_job(2, 32'd9, res, lat, ok);
        chk_delay = 0;
        checks++;
        if (!ok || lat - lat0 !== LW'(5)) begin
            failures++; $display("FAIL latency_delta got=%0d exp=5 (ok=%b)", lat - lat0, ok);
        end
    endtask

    task automatic test_fairness();
        int   order [5] = '{0, 1, 2, 3, 0};
        logic exps  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   t;
        logic [N-1:0] oh;
        do_reset();
        req_number = {32'd15, 32'd13, 32'd12, 32'd11};
        req_valid  = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << order[j];
            #1;
            t = 0;
            while (req_ready == '0 && t < 200) begin @(negedge clk); #1; t++; end
            checks++;
            if (req_ready !== oh) begin failures++; $display("FAIL fair_grant_%0d got=%b exp=%b", j, req_ready, oh); end
            if (j == 1) begin
                checks++;
                if (t !== 0) begin failures++; $display("FAIL back_to_back got wait=%0d exp=0", t); end
            end
            @(negedge clk);
            t = 0;
            while (rsp_valid == '0 && t < 200) begin @(negedge clk); t++; end
            checks++;
            if (rsp_valid !== oh || rsp_result !== exps[j]) begin
                failures++; $display("FAIL fair_rsp_%0d got valid=%b res=%b exp valid=%b res=%b", j, rsp_valid, rsp_result, oh, exps[j]);
            end
            if (j == 4) req_valid = '0;
            rsp_ready = oh;
            @(negedge clk);
            rsp_ready = '0;
        end
    endtask

    task automatic test_backpressure();
        int t;
        @(negedge clk);
        req_number[1*W +: W] = 32'd13; req_valid[1] = 1'b1; #1;
        t = 0;
        while (!req_ready[1] && t < 200) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        req_valid[1] = 1'b0;
        req_number[0 +: W] = 32'd4; req_valid[0] = 1'b1;
        t = 0;
        while (!rsp_valid[1] && t < 200) begin @(negedge clk); t++; end
        rsp_ready = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rsp_valid, rsp_result, req_ready} !== {4'b0010, 1'b1, 4'b0000}) begin
                failures++; $display("FAIL hold_cycle_%0d got valid=%b res=%b rdy=%b exp valid=0010 res=1 rdy=0000", c, rsp_valid, rsp_result, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = '0; #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL release_next_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 1'b0) begin
            failures++; $display("FAIL release_rsp got valid=%b res=%b exp valid=0001 res=0", rsp_valid, rsp_result);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int            t, seen;
        logic          res, ok;
        logic [LW-1:0] lat;
        chk_delay = 20;
        @(negedge clk);
        req_number[1*W +: W] = 32'd97; req_valid[1] = 1'b1; #1;
        t = 0;
        while (!req_ready[1] && t < 200) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        req_valid[1] = 1'b0;
        t = 0;
        while (!chk_ack && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0; #1;
        checks++;
        if ({req_ready, rsp_valid, chk_valid, chk_ack, busy, rsp_result, chk_number, last_latency, grant_id} !== '0) begin
            failures++; $display("FAIL midreset_outputs got ack=%b busy=%b grant=%0d lat=%0d num=%0d exp all 0", chk_ack, busy, grant_id, last_latency, chk_number);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_delay = 0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (rsp_valid != '0) seen++; end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL midreset_no_rsp got=%0d cycles exp=0", seen); end
        run_job(1, 32'd5, res, lat, ok);
        checks++;
        if (!ok || res !== 1'b1) begin failures++; $display("FAIL after_reset_job got ok=%b res=%b exp ok=1 res=1", ok, res); end
    endtask

    task automatic test_wrap();
        int            t;
        logic          res, ok;
        logic [LW-1:0] lat;
        run_job(3, 32'd3, res, lat, ok);
        checks++;
        if (!ok || res !== 1'b1) begin failures++; $display("FAIL wrap_first got ok=%b res=%b exp ok=1 res=1", ok, res); end
        @(negedge clk);
        req_number[0 +: W] = 32'd8;  req_valid[0] = 1'b1;
        req_number[3*W +: W] = 32'd17; req_valid[3] = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 1'b0) begin
            failures++; $display("FAIL wrap_rsp0 got valid=%b res=%b exp valid=0001 res=0", rsp_valid, rsp_result);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0; #1;
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_grant3 got=%b exp=1000", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        t = 0;
        while (!rsp_valid[3] && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_result !== 1'b1) begin
            failures++; $display("FAIL wrap_rsp3 got valid=%b res=%b exp valid=1000 res=1", rsp_valid, rsp_result);
        end
        rsp_ready[3] = 1'b1;
        @(negedge clk);
        rsp_ready[3] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_operands();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
